// File: rtl/demux_1x3_64bit_reg.sv
// demux_1x3_64bit_reg
// Routes one input word per cycle to one of three output channels. Each
// channel owns a single holding register with a full bit, so a channel can
// take a new word in the same cycle its consumer drains the current one.
// A select value of 3 is accepted and dropped, and it raises a sticky error flag.
module demux_1x3_64bit_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       S,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] X0,
    output logic [WIDTH-1:0] X1,
    output logic [WIDTH-1:0] X2,
    output logic             X0_valid,
    output logic             X1_valid,
    output logic             X2_valid,
    input  logic             X0_ready,
    input  logic             X1_ready,
    input  logic             X2_ready,
    output logic             err
);

    localparam int NCH = 3;

    logic [WIDTH-1:0] data_p1 [NCH];
    logic [NCH-1:0]   vld_p1;
    logic [NCH-1:0]   ready_vec;
    logic [NCH-1:0]   drain;
    logic [NCH-1:0]   load;
    logic             accept;
    logic             sel_invalid;
    logic             err_p1;

    assign ready_vec   = {X2_ready, X1_ready, X0_ready};
    assign drain       = vld_p1 & ready_vec;
    assign sel_invalid = (S == 2'd3);
    assign accept      = in_valid && in_ready;

    // Input side can proceed when the addressed channel is empty or draining now
    always_comb begin
        in_ready = 1'b1;
        case (S)
            2'd0:    in_ready = !vld_p1[0] || X0_ready;
            2'd1:    in_ready = !vld_p1[1] || X1_ready;
            2'd2:    in_ready = !vld_p1[2] || X2_ready;
            default: in_ready = 1'b1;
        endcase
    end

    // One-hot load strobe for the channel addressed by an accepted word
    always_comb begin
        load = '0;
        if (accept) begin
            case (S)
                2'd0:    load[0] = 1'b1;
                2'd1:    load[1] = 1'b1;
                2'd2:    load[2] = 1'b1;
                default: load    = '0;
            endcase
        end
    end

    // ---- stage p1: channel holding registers ----
    // Load wins over drain so a simultaneous drain+load keeps the channel full
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                data_p1[i] <= '0;
            end
            vld_p1 <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (load[i]) begin
                    data_p1[i] <= A;
                    vld_p1[i]  <= 1'b1;
                end else if (drain[i]) begin
                    vld_p1[i]  <= 1'b0;
                end
            end
        end
    end

    // Sticky error: set by any accepted word with an invalid select, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_p1 <= 1'b0;
        end else if (accept && sel_invalid) begin
            err_p1 <= 1'b1;
        end
    end

    assign X0       = data_p1[0];
    assign X1       = data_p1[1];
    assign X2       = data_p1[2];
    assign X0_valid = vld_p1[0];
    assign X1_valid = vld_p1[1];
    assign X2_valid = vld_p1[2];
    assign err      = err_p1;

endmodule

// File: doc/demux_1x3_64bit_reg.md
DEMUX_1X3_64BIT_REG -- requirements
Module: demux_1x3_64bit_reg

Interface
REQ-001 SHALL have parameter: WIDTH, 64, data width of input and all output channels.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 SHALL have port: A  input  WIDTH  input data word.
REQ-005 SHALL have port: S  input  2  destination select; 0->channel 0, 1->channel 1, 2->channel 2, 3->invalid.
REQ-006 SHALL have port: in_valid  input  1  A/S valid this cycle.
REQ-007 SHALL have port: in_ready  output  1  block accepts A/S this cycle.
REQ-008 SHALL have ports: X0, X1, X2  output  WIDTH each  channel data, driven from holding registers.
REQ-009 SHALL have ports: X0_valid, X1_valid, X2_valid  output  1 each  channel holds an undelivered word.
REQ-010 SHALL have ports: X0_ready, X1_ready, X2_ready  input  1 each  channel consumer accepts word this cycle.
REQ-011 SHALL have port: err  output  1  sticky flag, a word with S=3 was accepted.

Function
REQ-012 SHALL contain one WIDTH-bit holding register and one full bit per channel; Xi = register i, Xi_valid = full bit i.
REQ-013 SHALL define input transfer as in_valid && in_ready on a rising edge; output transfer i as Xi_valid && Xi_ready.
REQ-014 SHALL drive in_ready combinationally: S in 0..2 -> (!full[S] || X[S]_ready); S=3 -> 1.
REQ-015 SHALL, on input transfer with S in 0..2, load A into register S and set full[S]; word visible on X[S] with X[S]_valid=1 the next cycle (latency 1).
REQ-016 SHALL, on output transfer i without simultaneous load of channel i, clear full[i]; register i keeps its value.
REQ-017 SHALL, on output transfer i coinciding with load of channel i, load new word and keep full[i]=1 (back-to-back throughput of one word/cycle/channel).
REQ-018 SHALL treat channels independently: load of one channel and drain of any other channel in the same cycle both take effect.
REQ-019 SHALL, on input transfer with S=3, discard A, change no channel state, and set err=1.
REQ-020 SHALL hold err at 1 until reset; no other clear.
REQ-021 SHALL never overwrite a full channel that is not being drained in the same cycle (in_ready=0 forces stall).
REQ-022 SHALL keep Xi stable while Xi_valid=1 and Xi_ready=0.
REQ-023 SHALL ignore A and S when in_valid=0; no state change from the input side.

Reset
REQ-024 SHALL, while reset=1 at a rising edge, clear X0, X1, X2 to 0, all Xi_valid to 0, err to 0, regardless of in_valid/Xi_ready.
REQ-025 SHALL discard any word accepted or pending in the cycle reset is asserted (reset dominates load and drain).
REQ-026 SHALL drive in_ready per REQ-014 during reset (combinational), but no transfer takes effect.

Verification
REQ-027 SHALL cover: reset 2 cycles -> X0=X1=X2=0, all Xi_valid=0, err=0.
REQ-028 SHALL cover: all Xi_ready=1; A=11,S=0 then A=22,S=1 then A=33,S=2, in_valid=1 consecutive cycles -> X0=11, X1=22, X2=33 each valid exactly one cycle, one cycle after acceptance.
REQ-029 SHALL cover: X0_ready=0; A=11,S=0 accepted; then A=44,S=0 -> in_ready=0, X0 stays 11; raise X0_ready -> same cycle in_ready=1, next cycle X0=44 valid.
REQ-030 SHALL cover: channel 1 full, X1_ready=1, A=55,S=1 same cycle -> X1=55, X1_valid stays 1 (no bubble); simultaneous drain of channel 2 completes.
REQ-031 SHALL cover: A=66,S=3,in_valid=1 -> in_ready=1, no Xi_valid change, err=1 next cycle and remains 1 through later valid traffic.
REQ-032 SHALL cover: reset asserted with channel 0 full and A=77,S=0 in_valid=1 -> next cycle X0=0, X0_valid=0, err=0.
